// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, TAP transition function,
// host opcodes and host FSM states.
package jtag_pkg;

    localparam logic [4:0] TestLogicReset = 5'h00;
    localparam logic [4:0] RunTestOrIdle  = 5'h01;
    localparam logic [4:0] SelectDrScan   = 5'h02;
    localparam logic [4:0] SelectIrScan   = 5'h03;
    localparam logic [4:0] CaptureDr      = 5'h04;
    localparam logic [4:0] CaptureIr      = 5'h05;
    localparam logic [4:0] ShiftDr        = 5'h06;
    localparam logic [4:0] ShiftIr        = 5'h07;
    localparam logic [4:0] Exit1Dr        = 5'h08;
    localparam logic [4:0] Exit1Ir        = 5'h09;
    localparam logic [4:0] PauseDr        = 5'h0a;
    localparam logic [4:0] PauseIr        = 5'h0b;
    localparam logic [4:0] Exit2Dr        = 5'h0c;
    localparam logic [4:0] Exit2Ir        = 5'h0d;
    localparam logic [4:0] UpdateDr       = 5'h0e;
    localparam logic [4:0] UpdateIr       = 5'h0f;

    localparam logic [1:0] OP_RESET    = 2'b00;
    localparam logic [1:0] OP_IDLE     = 2'b01;
    localparam logic [1:0] OP_SHIFT_IR = 2'b10;
    localparam logic [1:0] OP_SHIFT_DR = 2'b11;

    typedef enum logic [1:0] {
        H_INIT = 2'd0,
        H_IDLE = 2'd1,
        H_RUN  = 2'd2,
        H_RSP  = 2'd3
    } host_state_t;

    function automatic logic [4:0] tap_next(input logic [4:0] s, input logic tms);
        logic [4:0] n;
        case (s)
            TestLogicReset: n = tms ? TestLogicReset : RunTestOrIdle;
            RunTestOrIdle:  n = tms ? SelectDrScan   : RunTestOrIdle;
            SelectDrScan:   n = tms ? SelectIrScan   : CaptureDr;
            SelectIrScan:   n = tms ? TestLogicReset : CaptureIr;
            CaptureDr:      n = tms ? Exit1Dr        : ShiftDr;
            CaptureIr:      n = tms ? Exit1Ir        : ShiftIr;
            ShiftDr:        n = tms ? Exit1Dr        : ShiftDr;
            ShiftIr:        n = tms ? Exit1Ir        : ShiftIr;
            Exit1Dr:        n = tms ? UpdateDr       : PauseDr;
            Exit1Ir:        n = tms ? UpdateIr       : PauseIr;
            PauseDr:        n = tms ? Exit2Dr        : PauseDr;
            PauseIr:        n = tms ? Exit2Ir        : PauseIr;
            Exit2Dr:        n = tms ? UpdateDr       : ShiftDr;
            Exit2Ir:        n = tms ? UpdateIr       : ShiftIr;
            UpdateDr:       n = tms ? SelectDrScan   : RunTestOrIdle;
            UpdateIr:       n = tms ? SelectDrScan   : RunTestOrIdle;
            default:        n = TestLogicReset;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_host_shifter.sv
// TDI/TDO shift datapath for jtag_host: serialises the command data LSB first
// and writes each sampled TDO bit at its own bit index.
module jtag_host_shifter
    import jtag_pkg::*;
#(
    parameter int DR_MAX = 32,
    parameter int CNT_W  = $clog2(DR_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DR_MAX-1:0] load_data,
    input  logic [CNT_W-1:0]  load_len,
    input  logic              step,
    input  logic              tdo,
    output logic              tdi_bit,
    output logic              last,
    output logic              done,
    output logic [DR_MAX-1:0] cap
);

    logic [DR_MAX-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  len;

    assign tdi_bit = sr[0];
    assign last    = (cnt == len - CNT_W'(1));
    assign done    = (cnt == len);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cap <= '0;
            cnt <= '0;
            len <= '0;
        end else if (load) begin
            sr  <= load_data;
            cap <= '0;
            cnt <= '0;
            len <= load_len;
        end else if (step && !done) begin
            sr  <= sr >> 1;
            cap <= cap | (DR_MAX'(tdo) << cnt);
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG initiator: runs RESET/IDLE/SHIFT_IR/SHIFT_DR commands as two-cycle TCK
// periods on the pins and mirrors the target TAP state.
module jtag_host #(
    parameter int DR_MAX = 32,
    parameter int LEN_W  = 6
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              tck_out,
    output logic              tms_out,
    output logic              tdi_out,
    input  logic              tdo_in,
    output logic [4:0]        tap_state
);
    import jtag_pkg::*;

    localparam int CNT_W = $clog2(DR_MAX + 1);
    localparam int K_W   = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;

    host_state_t      state, state_n;
    logic [K_W-1:0]   k, k_n, tot, tot_n, pre, pre_n, kp;
    logic [1:0]       op_r, op_n, st_op;
    logic             cur_shift, cur_shift_n;
    logic             tck_n, tms_n, tdi_n, ready_n, rsp_n;
    logic [4:0]       tap_n;
    logic             start, load, step;
    logic             sh_tdi, sh_last, sh_done;
    logic [CNT_W-1:0] n_clamp;

    always_comb begin
        if (cmd_len == '0)
            n_clamp = CNT_W'(1);
        else if (32'(cmd_len) > 32'(DR_MAX))
            n_clamp = CNT_W'(DR_MAX);
        else
            n_clamp = CNT_W'(cmd_len);
    end

    // INIT launches its own RESET sequence once; tot==0 marks "not yet launched".
    always_comb begin
        start = 1'b0;
        st_op = cmd_op;
        if (state == H_INIT && tot == '0) begin
            start = 1'b1;
            st_op = OP_RESET;
        end else if ((state == H_IDLE || state == H_RSP) && cmd_valid) begin
            start = 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        k_n         = k;
        tot_n       = tot;
        pre_n       = pre;
        op_n        = op_r;
        cur_shift_n = cur_shift;
        tck_n       = tck_out;
        tms_n       = tms_out;
        tdi_n       = tdi_out;
        ready_n     = cmd_ready;
        rsp_n       = 1'b0;
        tap_n       = tap_state;
        load        = 1'b0;
        step        = 1'b0;
        kp          = k + K_W'(1);

        if (start) begin
            load        = 1'b1;
            op_n        = st_op;
            k_n         = '0;
            cur_shift_n = 1'b0;
            tck_n       = 1'b0;
            tdi_n       = 1'b0;
            case (st_op)
                OP_RESET: begin tot_n = K_W'(6); pre_n = '0; tms_n = 1'b1; end
                OP_IDLE: begin tot_n = K_W'(cmd_len); pre_n = '0; tms_n = 1'b0; end
                OP_SHIFT_IR: begin tot_n = K_W'(n_clamp) + K_W'(6); pre_n = K_W'(4); tms_n = 1'b1; end
                default: begin tot_n = K_W'(n_clamp) + K_W'(5); pre_n = K_W'(3); tms_n = 1'b1; end
            endcase
            if (st_op == OP_IDLE && cmd_len == '0) begin
                state_n = H_RSP;
                rsp_n   = 1'b1;
                ready_n = 1'b1;
            end else begin
                state_n = (state == H_INIT) ? H_INIT : H_RUN;
                ready_n = 1'b0;
            end
        end else if (state == H_RUN || state == H_INIT) begin
            if (!tck_out) begin
                // Rising TCK: target moves state and we take its TDO bit.
                tck_n = 1'b1;
                tap_n = tap_next(tap_state, tms_out);
                step  = cur_shift;
            end else if (k == tot - K_W'(1)) begin
                tck_n       = 1'b0;
                tms_n       = 1'b0;
                tdi_n       = 1'b0;
                cur_shift_n = 1'b0;
                ready_n     = 1'b1;
                if (state == H_INIT) begin
                    state_n = H_IDLE;
                end else begin
                    state_n = H_RSP;
                    rsp_n   = 1'b1;
                end
            end else begin
                k_n   = kp;
                tck_n = 1'b0;
                if (op_r[1] && kp >= pre && !sh_done) begin
                    cur_shift_n = 1'b1;
                    tms_n       = sh_last;
                    tdi_n       = sh_tdi;
                end else begin
                    cur_shift_n = 1'b0;
                    tdi_n       = 1'b0;
                    case (op_r)
                        OP_RESET: tms_n = (kp < K_W'(5));
                        OP_IDLE:  tms_n = 1'b0;
                        default:  tms_n = (kp < pre) ? (op_r == OP_SHIFT_IR && kp == K_W'(1))
                                                     : (kp == tot - K_W'(2));
                    endcase
                end
            end
        end else if (state == H_RSP) begin
            state_n = H_IDLE;
        end
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            state     <= H_INIT;
            k         <= '0;
            tot       <= '0;
            pre       <= '0;
            op_r      <= OP_RESET;
            cur_shift <= 1'b0;
            tck_out   <= 1'b0;
            tms_out   <= 1'b1;
            tdi_out   <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            tap_state <= TestLogicReset;
        end else begin
            state     <= state_n;
            k         <= k_n;
            tot       <= tot_n;
            pre       <= pre_n;
            op_r      <= op_n;
            cur_shift <= cur_shift_n;
            tck_out   <= tck_n;
            tms_out   <= tms_n;
            tdi_out   <= tdi_n;
            cmd_ready <= ready_n;
            rsp_valid <= rsp_n;
            tap_state <= tap_n;
        end
    end

    jtag_host_shifter #(
        .DR_MAX (DR_MAX),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .clk       (tck),
        .rst       (trst),
        .load      (load),
        .load_data (cmd_data),
        .load_len  (n_clamp),
        .step      (step),
        .tdo       (tdo_in),
        .tdi_bit   (sh_tdi),
        .last      (sh_last),
        .done      (sh_done),
        .cap       (rsp_data)
    );

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host against a behavioural target TAP with a 1-bit
// bypass DR and an all-ones IR capture.
module tb_jtag_host;
    import jtag_pkg::*;

    logic        tck = 1'b0;
    logic        trst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tck_out, tms_out, tdi_out, tdo_in;
    logic [4:0]  tap_state;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tck_cnt = 0;
    logic [63:0] tms_log, tdi_log;
    bit          loop_en = 1'b0;

    jtag_host #(.DR_MAX(32), .LEN_W(6)) dut (
        .tck       (tck),
        .trst      (trst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tck_out   (tck_out),
        .tms_out   (tms_out),
        .tdi_out   (tdi_out),
        .tdo_in    (tdo_in),
        .tap_state (tap_state)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Independent TAP transition table for the target model.
    function automatic logic [4:0] ref_next(input logic [4:0] s, input logic m);
        case (s)
            5'h00: return m ? 5'h00 : 5'h01;
            5'h01: return m ? 5'h02 : 5'h01;
            5'h02: return m ? 5'h03 : 5'h04;
            5'h03: return m ? 5'h00 : 5'h05;
            5'h04: return m ? 5'h08 : 5'h06;
            5'h05: return m ? 5'h09 : 5'h07;
            5'h06: return m ? 5'h08 : 5'h06;
            5'h07: return m ? 5'h09 : 5'h07;
            5'h08: return m ? 5'h0e : 5'h0a;
            5'h09: return m ? 5'h0f : 5'h0b;
            5'h0a: return m ? 5'h0c : 5'h0a;
            5'h0b: return m ? 5'h0d : 5'h0b;
            5'h0c: return m ? 5'h0e : 5'h06;
            5'h0d: return m ? 5'h0f : 5'h07;
            5'h0e: return m ? 5'h02 : 5'h01;
            5'h0f: return m ? 5'h02 : 5'h01;
            default: return 5'h00;
        endcase
    endfunction

    logic [4:0] tgt_state;
    logic       byp, tgt_tdo;

    always @(posedge tck_out or posedge trst) begin
        if (trst) begin
            tgt_state <= 5'h00;
            byp       <= 1'b0;
        end else begin
            if (tgt_state == CaptureDr) byp <= 1'b0;
            else if (tgt_state == ShiftDr) byp <= tdi_out;
            tgt_state <= ref_next(tgt_state, tms_out);
        end
    end

    always @(negedge tck_out or posedge trst) begin
        if (trst) tgt_tdo <= 1'b0;
        else tgt_tdo <= (tgt_state == ShiftDr) ? byp : (tgt_state == ShiftIr);
    end
    assign tdo_in = tgt_tdo;

    always @(posedge tck_out) begin
        if (tck_cnt < 64) begin
            tms_log[tck_cnt] = tms_out;
            tdi_log[tck_cnt] = tdi_out;
        end
        tck_cnt++;
    end

    always @(negedge tck) begin
        if (loop_en && tck_out === 1'b1) chk("tap_loop", 64'(tap_state), 64'(tgt_state));
    end

    function automatic int eff_n(input int len);
        if (len == 0) return 1;
        if (len > 32) return 32;
        return len;
    endfunction

    function automatic logic [31:0] mask(input int n);
        logic [31:0] one;
        one = 32'd1;
        if (n >= 32) return 32'hFFFF_FFFF;
        return (one << n) - 32'd1;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           input bit noise, output logic [31:0] got, output int lat);
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 200) begin
            @(negedge tck);
            guard++;
        end
        if (cmd_ready !== 1'b1) chk("ready_timeout", 64'(cmd_ready), 64'd1);
        tck_cnt  = 0;
        tms_log  = '0;
        tdi_log  = '0;
        cmd_op   = op;
        cmd_len  = len;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(posedge tck);
        @(negedge tck);
        lat = 1;
        cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            if (noise) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_SHIFT_DR;
                cmd_len   = 6'd7;
                cmd_data  = 32'hFFFF_FFFF;
            end
            @(negedge tck);
            lat++;
        end
        cmd_valid = 1'b0;
        if (rsp_valid !== 1'b1) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
        got = rsp_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int          lat;
        bit          seen;
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        int          n, t;
        logic [31:0] exp;

        trst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_len = '0;
        cmd_data = '0;
        repeat (3) @(negedge tck);
        chk("rst_tck", 64'(tck_out), 64'd0);
        chk("rst_tms", 64'(tms_out), 64'd1);
        chk("rst_tdi", 64'(tdi_out), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_tap", 64'(tap_state), 64'h00);

        trst = 1'b0;
        tck_cnt = 0;
        tms_log = '0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge tck);
            if (c == 12) chk("init_ready_c12", 64'(cmd_ready), 64'd0);
            if (c == 13) chk("init_ready_c13", 64'(cmd_ready), 64'd1);
        end
        chk("init_tck_cnt", 64'(tck_cnt), 64'd6);
        chk("init_tms", tms_log, 64'h1F);
        chk("init_tap", 64'(tap_state), 64'h01);

        run_cmd(OP_SHIFT_IR, 6'd5, 32'h01, 1'b0, got, lat);
        chk("ir_rsp", 64'(got), 64'h1F);
        chk("ir_lat", 64'(lat), 64'd23);
        chk("ir_tck_cnt", 64'(tck_cnt), 64'd11);
        chk("ir_tms", tms_log, 64'h303);
        chk("ir_tdi", tdi_log, 64'h10);
        chk("ir_tap", 64'(tap_state), 64'h01);

        run_cmd(OP_SHIFT_DR, 6'd32, 32'hDEADBEEF, 1'b0, got, lat);
        chk("dr32_rsp", 64'(got), 64'hBD5B7DDE);
        chk("dr32_lat", 64'(lat), 64'd75);
        chk("dr32_tms", tms_log, 64'h0000_000C_0000_0001);

        run_cmd(OP_IDLE, 6'd10, 32'h0, 1'b1, got, lat);
        chk("idle10_tck_cnt", 64'(tck_cnt), 64'd10);
        chk("idle10_tms", tms_log, 64'h0);
        chk("idle10_lat", 64'(lat), 64'd21);
        chk("idle10_rsp", 64'(got), 64'h0);

        run_cmd(OP_IDLE, 6'd0, 32'h0, 1'b0, got, lat);
        chk("idle0_lat", 64'(lat), 64'd1);
        chk("idle0_tck_cnt", 64'(tck_cnt), 64'd0);

        run_cmd(OP_SHIFT_DR, 6'd40, 32'h12345678, 1'b0, got, lat);
        chk("dr40_tck_cnt", 64'(tck_cnt), 64'd37);
        chk("dr40_lat", 64'(lat), 64'd75);
        chk("dr40_rsp", 64'(got), 64'h2468ACF0);

        run_cmd(OP_RESET, 6'd0, 32'hFFFF_FFFF, 1'b0, got, lat);
        chk("reset_rsp", 64'(got), 64'h0);
        chk("reset_lat", 64'(lat), 64'd13);
        chk("reset_tms", tms_log, 64'h1F);

        run_cmd(OP_SHIFT_DR, 6'd0, 32'hFFFF_FFFF, 1'b0, got, lat);
        chk("dr0_tck_cnt", 64'(tck_cnt), 64'd6);
        chk("dr0_tms", tms_log, 64'h19);
        chk("dr0_tdi", tdi_log, 64'h08);
        chk("dr0_rsp", 64'(got), 64'h0);

        // Abort a SHIFT_DR during its shift bits.
        while (cmd_ready !== 1'b1) @(negedge tck);
        cmd_op = OP_SHIFT_DR;
        cmd_len = 6'd16;
        cmd_data = 32'hA5A5;
        cmd_valid = 1'b1;
        @(posedge tck);
        @(negedge tck);
        cmd_valid = 1'b0;
        repeat (9) @(negedge tck);
        trst = 1'b1;
        @(negedge tck);
        chk("abort_tck", 64'(tck_out), 64'd0);
        chk("abort_tms", 64'(tms_out), 64'd1);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_rsp_data", 64'(rsp_data), 64'd0);
        chk("abort_tap", 64'(tap_state), 64'h00);
        trst = 1'b0;
        tck_cnt = 0;
        tms_log = '0;
        seen = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge tck);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);
        chk("abort_ready_c13", 64'(cmd_ready), 64'd1);
        chk("abort_init_tms", tms_log, 64'h1F);
        chk("abort_init_tap", 64'(tap_state), 64'h01);

        loop_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op   = 2'($urandom_range(0, 3));
            len  = (op == OP_IDLE) ? 6'($urandom_range(0, 8)) : 6'($urandom_range(0, 40));
            data = $urandom;
            n    = eff_n(int'(len));
            case (op)
                OP_RESET:    begin t = 6;         exp = 32'h0; end
                OP_IDLE:     begin t = int'(len); exp = 32'h0; end
                OP_SHIFT_IR: begin t = n + 6;     exp = mask(n); end
                default:     begin t = n + 5;     exp = {data[30:0], 1'b0} & mask(n); end
            endcase
            run_cmd(op, len, data, 1'b0, got, lat);
            chk("loop_rsp", 64'(got), 64'(exp));
            chk("loop_lat", 64'(lat), 64'(2 * t + 1));
            chk("loop_tck_cnt", 64'(tck_cnt), 64'(t));
        end
        loop_en = 1'b0;
        chk("loop_end_tap", 64'(tap_state), 64'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
